vga_scanout: RTL and testbench

Raster scan-out stage downstream of the canvas colour arbiter. It generates 640x480@60 VGA timing from the 100 MHz system clock. It presents the current pixel coordinate to the layer generators and the arbiter, then samples the arbitrated 12-bit colour and drives the blanked RGB 4:4:4 and sync pins. Sync and blank are delayed to stay aligned with the colour path.

---
 rtl/vga_timing_pkg.sv | 47 ++++
 rtl/vga_delay_line.sv | 47 ++++
 rtl/vga_scanout.sv | 153 +++++++++++++++
 tb/tb_vga_scanout.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared raster timing constants, colour type and small helpers for the
//   VGA scan-out path. Imported by vga_scanout, the colour arbiter and the
//   layer generators so all agree on the default 640x480@60 raster.
package vga_timing_pkg;

  // Default 640x480@60 timing from a 100 MHz system clock
  localparam int unsigned DEF_CLK_DIV       = 4;
  localparam int unsigned DEF_H_VIS         = 640;
  localparam int unsigned DEF_H_FP          = 16;
  localparam int unsigned DEF_H_SYNC        = 96;
  localparam int unsigned DEF_H_BP          = 48;
  localparam int unsigned DEF_V_VIS         = 480;
  localparam int unsigned DEF_V_FP          = 10;
  localparam int unsigned DEF_V_SYNC        = 2;
  localparam int unsigned DEF_V_BP          = 33;
  localparam int unsigned DEF_COLOR_LATENCY = 0;

  // Derived totals and sync windows for the default raster
  localparam int unsigned H_TOTAL  = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL  = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned HS_START = DEF_H_VIS + DEF_H_FP;
  localparam int unsigned HS_END   = HS_START + DEF_H_SYNC;
  localparam int unsigned VS_START = DEF_V_VIS + DEF_V_FP;
  localparam int unsigned VS_END   = VS_START + DEF_V_SYNC;

  // Arbitrated colour {R[3:0],G[3:0],B[3:0]}
  typedef logic [11:0] color_t;

  // Per-pixel control bits that travel alongside the colour path
  typedef struct packed {
    logic hs;     // active-low horizontal sync
    logic vs;     // active-low vertical sync
    logic valid;  // coordinate inside the visible window
  } sync_t;

  // Idle value: syncs inactive, pixel blanked
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, valid: 1'b0};

  // True when lo <= v < hi
  function automatic logic in_window(input logic [9:0] v,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line
//   Parameterised-depth shift register with a shift enable. Used to keep
//   sync/valid aligned with a colour path that lags by DEPTH enabled
//   cycles. DEPTH = 0 degenerates to a plain wire.
// Ports:
//   clk    in          clock
//   rst_n  in          asynchronous active-low reset (stages load RST_VAL)
//   en     in          shift enable
//   d      in  WIDTH   data into the first stage
//   q      out WIDTH   data out of the last stage
module vga_delay_line #(
  parameter int unsigned      WIDTH   = 3,
  parameter int unsigned      DEPTH   = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    // Clock, reset and enable have no function without storage
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, en};
    assign q = d;
  end else begin : g_reg
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          stage[i] <= RST_VAL;
        end
      end else if (en) begin
        stage[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout
//   Raster scan-out stage. Divides the system clock into pixel periods,
//   runs the horizontal/vertical counters, presents the current coordinate
//   to the colour sources, then registers the arbitrated colour (blanked
//   outside the visible window) together with the syncs onto the pins.
//   Sync/valid are delayed by COLOR_LATENCY pixel periods so they stay
//   aligned with colour that arrives late from the arbiter.
// Ports:
//   clk          in      system clock (100 MHz)
//   rst_n        in      asynchronous active-low reset
//   color_in     in  12  arbitrated colour {R,G,B}, sampled on pix_tick
//   pix_x        out 10  horizontal count 0..H_TOTAL-1
//   pix_y        out 10  vertical count 0..V_TOTAL-1
//   pix_valid    out     pix_x/pix_y inside the visible window
//   pix_tick     out     one-clk strobe at the end of each pixel period
//   frame_start  out     one-clk pulse in the cycle the counters wrap to (0,0)
//   vga_r/g/b    out 4   pixel colour, zero while blanked
//   vga_hs/vs    out     active-low syncs
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV       = DEF_CLK_DIV,
  parameter int unsigned H_VIS         = DEF_H_VIS,
  parameter int unsigned H_FP          = DEF_H_FP,
  parameter int unsigned H_SYNC        = DEF_H_SYNC,
  parameter int unsigned H_BP          = DEF_H_BP,
  parameter int unsigned V_VIS         = DEF_V_VIS,
  parameter int unsigned V_FP          = DEF_V_FP,
  parameter int unsigned V_SYNC        = DEF_V_SYNC,
  parameter int unsigned V_BP          = DEF_V_BP,
  parameter int unsigned COLOR_LATENCY = DEF_COLOR_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] color_in,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_valid,
  output logic        pix_tick,
  output logic        frame_start,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs
);

  localparam int unsigned HT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(HT - 1);
  localparam logic [9:0] V_LAST   = 10'(VT - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_LO    = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_HI    = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_LO    = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_HI    = 10'(V_VIS + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q;
  logic [9:0]       h_q, v_q;
  logic [9:0]       h_nxt, v_nxt;
  logic             h_wrap, v_wrap;
  logic             valid_q;
  sync_t            sync_raw, sync_dly;
  color_t           rgb_q;
  logic             hs_q, vs_q;

  // ---------------------------------------------------------------- divider
  assign pix_tick = (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (pix_tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // --------------------------------------------------------------- counters
  always_comb begin
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    h_nxt  = h_wrap ? '0 : h_q + 10'd1;
    v_nxt  = v_q;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : v_q + 10'd1;
    end
  end

  // pix_valid is its own flop, loaded from the next coordinate, so the
  // output carries no decode logic after the registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      valid_q <= 1'b1;
    end else if (pix_tick) begin
      h_q     <= h_nxt;
      v_q     <= v_nxt;
      valid_q <= (h_nxt < H_VIS_C) && (v_nxt < V_VIS_C);
    end
  end

  assign pix_x       = h_q;
  assign pix_y       = v_q;
  assign pix_valid   = valid_q;
  assign frame_start = pix_tick & h_wrap & v_wrap;

  // ------------------------------------------------- sync / valid alignment
  always_comb begin
    sync_raw       = SYNC_IDLE;
    sync_raw.hs    = !in_window(h_q, HS_LO, HS_HI);
    sync_raw.vs    = !in_window(v_q, VS_LO, VS_HI);
    sync_raw.valid = valid_q;
  end

  vga_delay_line #(
    .WIDTH   ($bits(sync_t)),
    .DEPTH   (COLOR_LATENCY),
    .RST_VAL (SYNC_IDLE)
  ) u_align (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_tick),
    .d     (sync_raw),
    .q     (sync_dly)
  );

  // --------------------------------------------------------- output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (pix_tick) begin
      rgb_q <= sync_dly.valid ? color_t'(color_in) : '0;
      hs_q  <= sync_dly.hs;
      vs_q  <= sync_dly.vs;
    end
  end

  assign vga_r  = rgb_q[11:8];
  assign vga_g  = rgb_q[7:4];
  assign vga_b  = rgb_q[3:0];
  assign vga_hs = hs_q;
  assign vga_vs = vs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout
//   Two instances: dut0 with default 640x480 timing and combinational
//   colour (latency 0); dut1 with a tiny raster, CLK_DIV=2 and a 2-stage
//   registered colour source (latency 2). A reference raster model runs
//   per instance; expected pin values are queued when each coordinate is
//   presented and popped when the pins should show it.
module tb_vga_scanout;

  localparam int DIVP [2] = '{4, 2};
  localparam int HVIS [2] = '{640, 8};
  localparam int HFP  [2] = '{16, 2};
  localparam int HSY  [2] = '{96, 3};
  localparam int HBP  [2] = '{48, 3};
  localparam int VVIS [2] = '{480, 6};
  localparam int VFP  [2] = '{10, 1};
  localparam int VSY  [2] = '{2, 2};
  localparam int VBP  [2] = '{33, 2};
  localparam int LAT  [2] = '{0, 2};

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    int          x;
    int          y;
    logic        m;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] cin [2];
  logic [9:0]  px [2];
  logic [9:0]  py [2];
  logic        pv [2];
  logic        pt [2];
  logic        fs [2];
  logic [3:0]  r [2];
  logic [3:0]  g [2];
  logic [3:0]  b [2];
  logic        hs [2];
  logic        vs [2];
  logic        mode [2];
  logic [11:0] c1 = 12'h000;
  logic [11:0] c2 = 12'h000;

  always #5 clk = ~clk;

  function automatic logic [11:0] pat(input logic [9:0] x, input logic [9:0] y, input logic m);
    return m ? 12'hFFF : {x[3:0], y[3:0], 4'hA};
  endfunction

  assign cin[0] = pat(px[0], py[0], mode[0]);
  assign cin[1] = c2;

  // Colour source for dut1: two registered stages advancing on pix_tick
  always @(posedge clk) begin
    if (pt[1]) begin
      c1 <= pat(px[1], py[1], mode[1]);
      c2 <= c1;
    end
  end

  vga_scanout u_dut0 (
    .clk(clk), .rst_n(rst_n), .color_in(cin[0]),
    .pix_x(px[0]), .pix_y(py[0]), .pix_valid(pv[0]), .pix_tick(pt[0]),
    .frame_start(fs[0]), .vga_r(r[0]), .vga_g(g[0]), .vga_b(b[0]),
    .vga_hs(hs[0]), .vga_vs(vs[0])
  );

  vga_scanout #(
    .CLK_DIV(2), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .COLOR_LATENCY(2)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .color_in(cin[1]),
    .pix_x(px[1]), .pix_y(py[1]), .pix_valid(pv[1]), .pix_tick(pt[1]),
    .frame_start(fs[1]), .vga_r(r[1]), .vga_g(g[1]), .vga_b(b[1]),
    .vga_hs(hs[1]), .vga_vs(vs[1])
  );

  int   checks = 0;
  int   errors = 0;
  int   m_div [2];
  int   m_x [2];
  int   m_y [2];
  int   ticks [2];
  exp_t cur [2];
  exp_t q0 [$];
  exp_t q1 [$];
  int   cyc_n;
  logic meas_en;
  logic prev_hs0;
  int   hs_fall_tick [$];
  int   hs_fall_cyc [$];
  int   hs_rise_cyc [$];
  int   fs_ticks [$];
  int   vs_low;

  task automatic chk(input string tag, input int d, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s dut%0d observed=%h expected=%h t=%0t", tag, d, obs, exp, $time);
      $error("%s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  function automatic exp_t rst_exp();
    exp_t e;
    e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1; e.x = -1; e.y = -1; e.m = 1'b0;
    return e;
  endfunction

  function automatic exp_t mk_exp(input int d, input int x, input int y, input logic m);
    exp_t e;
    logic vis;
    vis   = (x < HVIS[d]) && (y < VVIS[d]);
    e.rgb = vis ? pat(10'(x), 10'(y), m) : 12'h000;
    e.hs  = !((x >= HVIS[d] + HFP[d]) && (x < HVIS[d] + HFP[d] + HSY[d]));
    e.vs  = !((y >= VVIS[d] + VFP[d]) && (y < VVIS[d] + VFP[d] + VSY[d]));
    e.x = x; e.y = y; e.m = m;
    return e;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_div[d] = 0; m_x[d] = 0; m_y[d] = 0; ticks[d] = 0;
      cur[d] = rst_exp();
    end
    q0.delete();
    q1.delete();
    for (int i = 0; i < LAT[1]; i++) q1.push_back(rst_exp());
    prev_hs0 = 1'b1;
  endtask

  // One system clock: compare at the falling edge, advance model after the rising edge
  task automatic cyc();
    logic et [2];
    exp_t e;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      et[d] = rst_n && (m_div[d] == DIVP[d] - 1);
      chk("pix_tick", d, 16'(pt[d]), 16'(et[d]));
      chk("pix_x", d, 16'(px[d]), 16'(m_x[d]));
      chk("pix_y", d, 16'(py[d]), 16'(m_y[d]));
      chk("pix_valid", d, 16'(pv[d]), 16'((m_x[d] < HVIS[d]) && (m_y[d] < VVIS[d])));
      chk("frame_start", d, 16'(fs[d]), 16'(et[d] && (m_x[d] == HVIS[d]+HFP[d]+HSY[d]+HBP[d]-1)
                                                  && (m_y[d] == VVIS[d]+VFP[d]+VSY[d]+VBP[d]-1)));
      chk("rgb", d, {4'h0, r[d], g[d], b[d]}, {4'h0, cur[d].rgb});
      chk("hs", d, 16'(hs[d]), 16'(cur[d].hs));
      chk("vs", d, 16'(vs[d]), 16'(cur[d].vs));
      if (et[d]) begin
        e = mk_exp(d, m_x[d], m_y[d], mode[d]);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
    if (meas_en && fs[1]) fs_ticks.push_back(ticks[1]);
    @(posedge clk);
    #1;
    cyc_n++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_div[d] = 0;
      end else if (et[d]) begin
        ticks[d]++;
        m_div[d] = 0;
        if (m_x[d] == HVIS[d]+HFP[d]+HSY[d]+HBP[d]-1) begin
          m_x[d] = 0;
          m_y[d] = (m_y[d] == VVIS[d]+VFP[d]+VSY[d]+VBP[d]-1) ? 0 : m_y[d] + 1;
        end else begin
          m_x[d]++;
        end
        if (d == 0) begin
          chk("sb_nonempty", d, 16'(q0.size() != 0), 16'd1);
          if (q0.size() != 0) cur[d] = q0.pop_front();
        end else begin
          chk("sb_nonempty", d, 16'(q1.size() != 0), 16'd1);
          if (q1.size() != 0) cur[d] = q1.pop_front();
        end
        if (cur[d].x == 5 && cur[d].y == 2 && !cur[d].m)
          chk("rgb_at_5_2", d, {4'h0, r[d], g[d], b[d]}, 16'h052A);
        if (d == 1 && meas_en && ticks[1] >= 100 && ticks[1] < 276 && !vs[1]) vs_low++;
      end else begin
        m_div[d]++;
      end
    end
    if (meas_en) begin
      if (prev_hs0 && !hs[0]) begin
        hs_fall_tick.push_back(ticks[0]);
        hs_fall_cyc.push_back(cyc_n);
      end
      if (!prev_hs0 && hs[0]) hs_rise_cyc.push_back(cyc_n);
    end
    prev_hs0 = hs[0];
  endtask

  task automatic chk_reset_pins();
    for (int d = 0; d < 2; d++) begin
      chk("rst_tick", d, 16'(pt[d]), 16'd0);
      chk("rst_xy", d, {px[d][7:0], py[d][7:0]}, 16'd0);
      chk("rst_valid", d, 16'(pv[d]), 16'd1);
      chk("rst_fs", d, 16'(fs[d]), 16'd0);
      chk("rst_rgb", d, {4'h0, r[d], g[d], b[d]}, 16'h0000);
      chk("rst_sync", d, {14'h0, hs[d], vs[d]}, 16'h0003);
    end
  endtask

  initial begin
    logic found;
    mode[0] = 1'b1;
    mode[1] = 1'b0;
    meas_en = 1'b0;
    cyc_n   = 0;
    vs_low  = 0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) cyc();
    chk_reset_pins();

    rst_n   = 1'b1;
    cyc_n   = 0;
    meas_en = 1'b1;
    repeat (4) cyc();
    chk("pix_x_after_first_tick", 0, 16'(px[0]), 16'd1);

    for (int i = 4; i < 3300; i++) begin
      if (i == 500) mode[1] = 1'b1;
      cyc();
    end
    mode[0] = 1'b0;
    for (int i = 3300; i < 7000; i++) cyc();
    meas_en = 1'b0;

    chk("hs_fall_count", 0, 16'(hs_fall_tick.size() >= 2), 16'd1);
    chk("hs_rise_count", 0, 16'(hs_rise_cyc.size() >= 1), 16'd1);
    if (hs_fall_tick.size() >= 2 && hs_rise_cyc.size() >= 1) begin
      chk("hs_first_fall_tick", 0, 16'(hs_fall_tick[0]), 16'd657);
      chk("hs_low_clks", 0, 16'(hs_rise_cyc[0] - hs_fall_cyc[0]), 16'd384);
      chk("hs_period_ticks", 0, 16'(hs_fall_tick[1] - hs_fall_tick[0]), 16'd800);
    end
    chk("vs_low_ticks_per_frame", 1, 16'(vs_low), 16'd32);
    chk("fs_count", 1, 16'(fs_ticks.size() >= 2), 16'd1);
    if (fs_ticks.size() >= 2) begin
      chk("fs_first_tick", 1, 16'(fs_ticks[0]), 16'd175);
      chk("fs_interval", 1, 16'(fs_ticks[1] - fs_ticks[0]), 16'd176);
    end

    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      cyc();
      found = (m_x[1] == 5) && (m_y[1] == 3);
    end
    chk("reach_5_3", 1, 16'(found), 16'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_pins();
    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (500) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
